airi5c_hasti_sram_responder: RTL and testbench
==============================================

Name: airi5c_hasti_sram_responder

Overview:
- AHB-Lite (HASTI) slave bridge: the responder at the far end of the core's AHB-Lite master port.
- Accepts single NONSEQ/SEQ transfers and turns them into a single-port synchronous SRAM interface (1-cycle read latency, byte-enabled writes).
- Generates hreadyout/hresp, including stall cycles for port collisions and the two-cycle ERROR response.
- Sits between the system interconnect and on-chip instruction/data SRAM.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the decoded region; must be aligned to the region size.
- MEM_ADDR_WIDTH, 12, SRAM word-address width; region size is 4*2^MEM_ADDR_WIDTH bytes.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hsel  in  1  slave select
- haddr  in  32  address-phase address
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- htrans  in  2  transfer type
- hwdata  in  32  data-phase write data
- hready  in  1  bus-level hready (ready-in)
- hrdata  out  32  read data
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- mem_en  out  1  SRAM access strobe
- mem_wen  out  1  SRAM write enable
- mem_addr  out  MEM_ADDR_WIDTH  SRAM word address
- mem_be  out  4  byte enables
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after a read strobe

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, mem_en=0, mem_wen=0, mem_be=0, all captured address/control registers 0.
- Reset asserted mid-transfer drops the pending transfer; no SRAM write is issued after reset.
- Accept: an address phase is accepted when hsel & htrans[1] & hready. IDLE/BUSY transfers, or hsel=0, give a zero-wait OKAY with no SRAM access.
- Error check in the address phase, on any of:
  - haddr outside [BASE_ADDR, BASE_ADDR + 4*2^MEM_ADDR_WIDTH)
  - hsize > 3'b010
  - halfword with haddr[0] = 1
  - word with haddr[1:0] != 0
- States: IDLE, RD, WR, RD_STALL, ERR1, ERR2. Each state below gives the behaviour of the data phase it represents.
- IDLE: hreadyout=1, hresp=0.
- RD: hreadyout=1, hrdata=mem_rdata.
- WR: hreadyout=1. Drives mem_en=1, mem_wen=1, mem_addr/mem_be from the captured address phase, mem_wdata=hwdata.
- RD_STALL: hreadyout=0, hrdata=0. Issues a read from the captured address; next state RD.
- ERR1: hreadyout=0, hresp=1, no SRAM access; next state ERR2 unconditionally.
- ERR2: hreadyout=1, hresp=1.
- Next state from IDLE/RD/WR/ERR2 is chosen by the accepted transfer:
  - error -> ERR1
  - write -> WR (capture address, size)
  - read in IDLE/RD/ERR2 -> RD, with mem_en=1, mem_wen=0, mem_addr=haddr word bits driven combinationally in the same cycle
  - read in WR (port busy with the write) -> RD_STALL (capture address)
  - nothing accepted -> IDLE
- Latency:
  - read: 0 wait states, except 1 wait state directly after a write
  - write: 0 wait states
  - error: 1 wait state plus the ERROR cycle
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - hwdata lanes pass through unshifted.
- hrdata is 0 outside RD.
- Back-to-back transfers are pipelined; the address phase overlaps the previous data phase.

Decomposition:
- HTRANS/HSIZE/HRESP encodings come from airi5c_hasti_constants.vh. Add to it: HASTI_SIZE_BYTE/HALF/WORD (if absent) and the state encoding localparams.
- One combinational sub-module, airi5c_hasti_be_gen: inputs size and addr[1:0]; outputs mem_be and a misaligned flag.

Test Plan:
- Write word 0xDEADBEEF at BASE+0x10, then read it back-to-back -> WR cycle has mem_be=4'hF, mem_addr=4; the read takes 1 stall cycle (hreadyout=0), then hrdata=0xDEADBEEF with OKAY.
- Byte write 0xAA at BASE+0x13 (hwdata 0xAA000000) -> mem_be=4'b1000; a following word read (separated by an IDLE) returns 0xAA in [31:24], other bytes unchanged, with no stall.
- Two consecutive reads at BASE+0x0 and BASE+0x4 -> no wait states; hrdata updates every cycle; mem_addr 0 then 1.
- Read at BASE+0x2 with hsize=word -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1); mem_en stays 0. Same for haddr=BASE-4.
- htrans=BUSY and hsel=0 cycles interleaved with transfers -> OKAY, hreadyout=1, mem_en=0 on those cycles.
- Assert reset during the WR data phase -> mem_en/mem_wen drop to 0 immediately; hreadyout=1; state IDLE; the next read sees the old contents.

Source files
------------

// File: rtl/airi5c_hasti_sram_responder_pkg.sv
// Shared HASTI encodings and responder state type for the SRAM responder slice.
// Transfer, size and response codes follow the AHB-Lite (HASTI) bus definitions.
package airi5c_hasti_sram_responder_pkg;

  localparam logic [1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] HASTI_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HASTI_TRANS_SEQ    = 2'b11;

  localparam logic [2:0] HASTI_SIZE_BYTE = 3'b000;
  localparam logic [2:0] HASTI_SIZE_HALF = 3'b001;
  localparam logic [2:0] HASTI_SIZE_WORD = 3'b010;

  localparam logic HASTI_RESP_OKAY  = 1'b0;
  localparam logic HASTI_RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR       = 3'd2,
    ST_RD_STALL = 3'd3,
    ST_ERR1     = 3'd4,
    ST_ERR2     = 3'd5
  } hasti_state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic hasti_trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/airi5c_hasti_be_gen.sv
// Byte-enable generator: maps transfer size and low address bits to SRAM lane
// enables and flags halfword/word accesses that are not naturally aligned.
module airi5c_hasti_be_gen
  import airi5c_hasti_sram_responder_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_addr,
  output logic [3:0] o_be,
  output logic       o_misaligned
);

  always_comb begin
    o_be         = 4'b0000;
    o_misaligned = 1'b0;
    case (i_size)
      HASTI_SIZE_BYTE: o_be = 4'b0001 << i_addr;
      HASTI_SIZE_HALF: begin
        o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
        o_misaligned = i_addr[0];
      end
      HASTI_SIZE_WORD: begin
        o_be         = 4'b1111;
        o_misaligned = |i_addr;
      end
      default: o_be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/airi5c_hasti_sram_responder.sv
// AHB-Lite (HASTI) slave that fronts a single-port synchronous SRAM with a
// one-cycle read latency, byte-enabled writes and a two-cycle ERROR response.
module airi5c_hasti_sram_responder
  import airi5c_hasti_sram_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int          MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hsel,
  input  logic [31:0]               haddr,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [1:0]                htrans,
  input  logic [31:0]               hwdata,
  input  logic                      hready,
  output logic [31:0]               hrdata,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic                      mem_en,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                mem_be,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata
);

  localparam int REGION_LSB = MEM_ADDR_WIDTH + 2;

  hasti_state_e              r_state;
  hasti_state_e              w_next_state;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [3:0]                r_be;

  logic                      w_accept;
  logic                      w_in_region;
  logic                      w_bad_size;
  logic                      w_misaligned;
  logic                      w_error;
  logic                      w_capture;
  logic [3:0]                w_be;
  logic [MEM_ADDR_WIDTH-1:0] w_haddr_word;

  airi5c_hasti_be_gen u_be_gen (
    .i_size       (hsize),
    .i_addr       (haddr[1:0]),
    .o_be         (w_be),
    .o_misaligned (w_misaligned)
  );

  // The region is size-aligned, so an in-range address matches BASE_ADDR above the word index.
  assign w_in_region  = (haddr[31:REGION_LSB] == BASE_ADDR[31:REGION_LSB]);
  assign w_bad_size   = (hsize > HASTI_SIZE_WORD);
  assign w_error      = !w_in_region || w_bad_size || w_misaligned;
  assign w_accept     = hsel && hasti_trans_active(htrans) && hready;
  assign w_haddr_word = haddr[REGION_LSB-1:2];

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    hreadyout    = 1'b1;
    hresp        = HASTI_RESP_OKAY;
    hrdata       = 32'h0;
    mem_en       = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = r_addr;
    mem_be       = 4'b0000;
    mem_wdata    = 32'h0;

    case (r_state)
      ST_RD: hrdata = mem_rdata;
      ST_WR: begin
        mem_en    = 1'b1;
        mem_wen   = 1'b1;
        mem_be    = r_be;
        mem_wdata = hwdata;
      end
      ST_RD_STALL: begin
        hreadyout    = 1'b0;
        mem_en       = 1'b1;
        w_next_state = ST_RD;
      end
      ST_ERR1: begin
        hreadyout    = 1'b0;
        hresp        = HASTI_RESP_ERROR;
        w_next_state = ST_ERR2;
      end
      ST_ERR2: hresp = HASTI_RESP_ERROR;
      default: ;
    endcase

    // Every state that completes its data phase this cycle also takes the next address phase.
    if (r_state != ST_RD_STALL && r_state != ST_ERR1) begin
      w_next_state = ST_IDLE;
      if (w_accept) begin
        if (w_error) begin
          w_next_state = ST_ERR1;
        end else if (hwrite) begin
          w_next_state = ST_WR;
          w_capture    = 1'b1;
        end else if (r_state == ST_WR) begin
          // The port is busy with the write, so the read is replayed next cycle.
          w_next_state = ST_RD_STALL;
          w_capture    = 1'b1;
        end else begin
          w_next_state = ST_RD;
          mem_en       = 1'b1;
          mem_addr     = w_haddr_word;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_be    <= 4'b0000;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_addr <= w_haddr_word;
        r_be   <= w_be;
      end
    end
  end

endmodule

// File: tb/tb_airi5c_hasti_sram_responder.sv
// Directed bench for the HASTI SRAM responder: per-cycle vector table plus a
// hand-written reset-during-write sequence, against a behavioural SRAM.
module tb_airi5c_hasti_sram_responder;

  localparam logic [31:0] B  = 32'h8000_0000;
  localparam logic [1:0]  ID = 2'b00;
  localparam logic [1:0]  BZ = 2'b01;
  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  SQ = 2'b11;
  localparam logic [2:0]  BY = 3'd0;
  localparam logic [2:0]  HW = 3'd1;
  localparam logic [2:0]  WD = 3'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        mem_en;
  logic        mem_wen;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_init;

  logic [31:0] sram [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic        e_en;
    logic        e_wen;
    logic [11:0] e_maddr;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs[$];

  airi5c_hasti_sram_responder #(
    .BASE_ADDR      (32'h8000_0000),
    .MEM_ADDR_WIDTH (12)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hsel      (hsel),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .htrans    (htrans),
    .hwdata    (hwdata),
    .hready    (hready),
    .hrdata    (hrdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single responder on the bus: ready-in follows our own ready-out.
  assign hready = hreadyout;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) sram[i] <= 32'h1122_3300 | 32'(i);
    end else if (mem_en) begin
      if (mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic sel, input logic [1:0] trans,
                     input logic wr, input logic [2:0] size, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic e_rdy, input logic e_resp,
                     input logic [31:0] e_rdata, input logic e_en, input logic e_wen,
                     input logic [11:0] e_maddr, input logic [3:0] e_be);
    vec_t v;
    v.name = n; v.sel = sel; v.trans = trans; v.wr = wr; v.size = size;
    v.addr = addr; v.wdata = wdata; v.e_rdy = e_rdy; v.e_resp = e_resp;
    v.e_rdata = e_rdata; v.e_en = e_en; v.e_wen = e_wen; v.e_maddr = e_maddr;
    v.e_be = e_be;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hwdata = wdata;
  endtask

  initial begin
    // Each row: address phase of this cycle, hwdata for the current data phase,
    // and the outputs expected before the next rising edge.
    //   name            sel trans wr size addr        wdata          rdy resp rdata          en wen maddr   be
    add("idle0",         0, ID, 0, WD, B,          32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("wr_word_ap",    1, NS, 1, WD, B+32'h10,   32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("wr_word_dp",    1, NS, 0, WD, B+32'h10,   32'hDEADBEEF,  1, 0, 32'h0,          1, 1, 12'h4,   4'hF);
    add("rd_stall",      0, ID, 0, WD, B,          32'h0,         0, 0, 32'h0,          1, 0, 12'h4,   4'h0);
    add("rd_after_wr",   0, ID, 0, WD, B,          32'h0,         1, 0, 32'hDEADBEEF,   0, 0, 12'h0,   4'h0);
    add("wr_byte_ap",    1, NS, 1, BY, B+32'h13,   32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("wr_byte_dp",    1, ID, 0, WD, B,          32'hAA000000,  1, 0, 32'h0,          1, 1, 12'h4,   4'h8);
    add("rd_byte_ap",    1, NS, 0, WD, B+32'h10,   32'h0,         1, 0, 32'h0,          1, 0, 12'h4,   4'h0);
    add("rd_byte_dp",    1, ID, 0, WD, B,          32'h0,         1, 0, 32'hAAADBEEF,   0, 0, 12'h0,   4'h0);
    add("rd0_ap",        1, NS, 0, WD, B,          32'h0,         1, 0, 32'h0,          1, 0, 12'h0,   4'h0);
    add("rd1_ap",        1, SQ, 0, WD, B+32'h4,    32'h0,         1, 0, 32'h11223300,   1, 0, 12'h1,   4'h0);
    add("rd1_dp",        1, ID, 0, WD, B,          32'h0,         1, 0, 32'h11223301,   0, 0, 12'h0,   4'h0);
    add("err_mis_ap",    1, NS, 0, WD, B+32'h2,    32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_mis_e1",    0, ID, 0, WD, B,          32'h0,         0, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_mis_e2",    0, ID, 0, WD, B,          32'h0,         1, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_lo_ap",     1, NS, 0, WD, B-32'h4,    32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_lo_e1",     0, ID, 0, WD, B,          32'h0,         0, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_lo_e2",     1, NS, 0, WD, B+32'h4,    32'h0,         1, 1, 32'h0,          1, 0, 12'h1,   4'h0);
    add("rd_e2_dp",      1, BZ, 0, WD, B+32'h8,    32'h0,         1, 0, 32'h11223301,   0, 0, 12'h0,   4'h0);
    add("nosel",         0, SQ, 0, WD, B,          32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("wr_half_ap",    1, NS, 1, HW, B+32'h6,    32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("wr_half_dp",    1, BZ, 0, WD, B,          32'hBEEF0000,  1, 0, 32'h0,          1, 1, 12'h1,   4'hC);
    add("rd_half_ap",    1, NS, 0, HW, B+32'h6,    32'h0,         1, 0, 32'h0,          1, 0, 12'h1,   4'h0);
    add("rd_half_dp",    0, NS, 0, WD, B,          32'h0,         1, 0, 32'hBEEF3301,   0, 0, 12'h0,   4'h0);
    add("err_size_ap",   1, NS, 0, 3'd3, B,        32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_size_e1",   0, ID, 0, WD, B,          32'h0,         0, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_size_e2",   0, ID, 0, WD, B,          32'h0,         1, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_half_ap",   1, NS, 0, HW, B+32'h1,    32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_half_e1",   0, ID, 0, WD, B,          32'h0,         0, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_half_e2",   0, ID, 0, WD, B,          32'h0,         1, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("rd_top_ap",     1, NS, 0, WD, B+32'h3FFC, 32'h0,         1, 0, 32'h0,          1, 0, 12'hFFF, 4'h0);
    add("rd_top_dp",     1, NS, 0, WD, B+32'h4000, 32'h0,         1, 0, 32'h11223FFF,   0, 0, 12'h0,   4'h0);
    add("err_hi_e1",     0, ID, 0, WD, B,          32'h0,         0, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("err_hi_e2",     0, ID, 0, WD, B,          32'h0,         1, 1, 32'h0,          0, 0, 12'h0,   4'h0);
    add("idle_end",      0, ID, 0, WD, B,          32'h0,         1, 0, 32'h0,          0, 0, 12'h0,   4'h0);

    reset    = 1'b1;
    mem_init = 1'b1;
    drive(1'b0, ID, 1'b0, WD, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.hreadyout", 32'(hreadyout), 32'h1);
    check("reset.hresp",     32'(hresp),     32'h0);
    check("reset.hrdata",    hrdata,         32'h0);
    check("reset.mem_en",    32'(mem_en),    32'h0);
    check("reset.mem_wen",   32'(mem_wen),   32'h0);
    check("reset.mem_be",    32'(mem_be),    32'h0);
    reset    = 1'b0;
    mem_init = 1'b0;

    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      drive(vecs[k].sel, vecs[k].trans, vecs[k].wr, vecs[k].size, vecs[k].addr, vecs[k].wdata);
      @(negedge clk);
      check({vecs[k].name, ".hreadyout"}, 32'(hreadyout), 32'(vecs[k].e_rdy));
      check({vecs[k].name, ".hresp"},     32'(hresp),     32'(vecs[k].e_resp));
      check({vecs[k].name, ".hrdata"},    hrdata,         vecs[k].e_rdata);
      check({vecs[k].name, ".mem_en"},    32'(mem_en),    32'(vecs[k].e_en));
      if (vecs[k].e_en) begin
        check({vecs[k].name, ".mem_wen"},  32'(mem_wen),  32'(vecs[k].e_wen));
        check({vecs[k].name, ".mem_addr"}, 32'(mem_addr), 32'(vecs[k].e_maddr));
      end
      if (vecs[k].e_wen) begin
        check({vecs[k].name, ".mem_be"},    32'(mem_be), 32'(vecs[k].e_be));
        check({vecs[k].name, ".mem_wdata"}, mem_wdata,   vecs[k].wdata);
      end
    end

    // Reset asserted in the middle of a write data phase.
    @(posedge clk);
    #1;
    drive(1'b1, NS, 1'b1, WD, B+32'h20, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, ID, 1'b0, WD, B, 32'h12345678);
    #1;
    check("rstwr.pre_mem_en",  32'(mem_en),  32'h1);
    check("rstwr.pre_mem_wen", 32'(mem_wen), 32'h1);
    reset = 1'b1;
    #1;
    check("rstwr.mem_en",    32'(mem_en),    32'h0);
    check("rstwr.mem_wen",   32'(mem_wen),   32'h0);
    check("rstwr.hreadyout", 32'(hreadyout), 32'h1);
    check("rstwr.hresp",     32'(hresp),     32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, NS, 1'b0, WD, B+32'h20, 32'h0);
    @(negedge clk);
    check("rstwr.rd_mem_en",   32'(mem_en),    32'h1);
    check("rstwr.rd_mem_addr", 32'(mem_addr),  32'h8);
    check("rstwr.rd_ready",    32'(hreadyout), 32'h1);
    @(posedge clk);
    #1;
    drive(1'b0, ID, 1'b0, WD, B, 32'h0);
    @(negedge clk);
    check("rstwr.old_data", hrdata, 32'h11223308);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
